// File: rtl/load_store_unit.sv
// Load/store unit: sits between the EX/MEM pipeline register and a word-addressed
// data memory. Handles byte/half/word loads with extension, sub-word stores as a
// registered read-modify-write, and rejects misaligned or out-of-range accesses
// without touching memory. One request in flight at a time.
module load_store_unit #(
  parameter int unsigned DEPTH      = 1024,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_STORE,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t      r_state;
  state_t      w_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_offset;
  logic [31:0] r_mem_addr;
  logic [31:0] r_wdata;
  logic        r_error;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_error;
  logic [1:0]  w_byte_lane;
  logic        w_half_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_accept = req_valid & req_ready;

  // Classify the incoming request: bad size, misalignment, or word index past the end.
  assign w_error = (req_size == 2'd3)
                 || ((req_size == SZ_HALF) && req_addr[0])
                 || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                 || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

  // Physical lane inside the 32-bit word for the latched byte offset.
  assign w_byte_lane = BIG_ENDIAN ? ~r_offset    : r_offset;
  assign w_half_lane = BIG_ENDIAN ? ~r_offset[1] : r_offset[1];

  assign mem_addr   = r_mem_addr;
  assign resp_rdata = r_rdata;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and control outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_error = 1'b0;
    mem_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_error)               w_next = S_RESP;
          else if (!req_write)       w_next = S_LOAD;
          else if (req_size == SZ_WORD) w_next = S_STORE;
          else                       w_next = S_RMW_RD;
        end
      end
      S_LOAD:   w_next = S_RESP;
      S_RMW_RD: w_next = S_STORE;
      S_STORE: begin
        mem_we = ~rst;
        w_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_error = r_error;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the request fields on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write    <= 1'b0;
      r_size     <= 2'd0;
      r_signed   <= 1'b0;
      r_offset   <= 2'd0;
      r_mem_addr <= 32'd0;
      r_wdata    <= 32'd0;
      r_error    <= 1'b0;
    end else if (w_accept) begin
      r_write    <= req_write;
      r_size     <= req_size;
      r_signed   <= req_signed;
      r_offset   <= req_addr[1:0];
      r_mem_addr <= {2'b00, req_addr[31:2]};
      r_wdata    <= req_wdata;
      r_error    <= w_error;
    end
  end

  // Load lane selection with sign/zero extension, and store word merge.
  always_comb begin
    w_byte      = mem_rdata[{w_byte_lane, 3'b000} +: 8];
    w_half      = mem_rdata[{w_half_lane, 4'b0000} +: 16];
    w_load_data = mem_rdata;
    case (r_size)
      SZ_BYTE: w_load_data = {{24{w_byte[7] & r_signed}}, w_byte};
      SZ_HALF: w_load_data = {{16{w_half[15] & r_signed}}, w_half};
      default: w_load_data = mem_rdata;
    endcase

    mem_wdata = 32'd0;
    if ((r_state == S_STORE) && r_write) begin
      mem_wdata = r_merge;
      case (r_size)
        SZ_BYTE: mem_wdata[{w_byte_lane, 3'b000} +: 8]  = r_wdata[7:0];
        SZ_HALF: mem_wdata[{w_half_lane, 4'b0000} +: 16] = r_wdata[15:0];
        default: mem_wdata = r_wdata;
      endcase
    end
  end

  // Load result and read-modify-write merge capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'd0;
      r_merge <= 32'd0;
    end else begin
      if (r_state == S_LOAD)   r_rdata <= w_load_data;
      if (r_state == S_RMW_RD) r_merge <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 1024-word behavioural data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];

  int n_assert = 0;
  int n_fail   = 0;

  // Per-transaction observations.
  int          resp_cyc;
  int          we_cnt;
  int          we_cyc;
  logic [31:0] we_data;
  logic [31:0] we_addr;
  logic        got_err;
  logic [31:0] got_rdata;
  int          bad_cnt;

  load_store_unit #(.DEPTH(1024), .BIG_ENDIAN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_error (resp_error),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'd0;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and watch up to 6 cycles after the accept edge.
  // Cycle k is the interval following the k-th posedge after accept.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    resp_cyc  = 0;
    we_cnt    = 0;
    we_cyc    = 0;
    we_data   = 32'd0;
    we_addr   = 32'd0;
    got_err   = 1'b0;
    got_rdata = 32'd0;
    for (int k = 1; k <= 6 && resp_cyc == 0; k++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++;
        we_cyc  = k;
        we_data = mem_wdata;
        we_addr = mem_addr;
      end
      if (resp_valid) begin
        resp_cyc  = k;
        got_err   = resp_error;
        got_rdata = resp_rdata;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[8]     = 32'h8C0AF0FF;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_resp_rdata", resp_rdata,          32'd0);
    check("rst_mem_addr",   mem_addr,            32'd0);
    check("rst_mem_wdata",  mem_wdata,           32'd0);
    check("rst_mem_we",     {31'd0, mem_we},     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1. byte loads
    do_req(1'b0, 2'd0, 1'b1, 32'h23, 32'd0);
    check("lb23_lat",   resp_cyc, 2);
    check("lb23_err",   {31'd0, got_err}, 32'd0);
    check("lb23_data",  got_rdata, 32'hFFFFFFFF);
    check("lb23_we",    we_cnt, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h22, 32'd0);
    check("lbu22_lat",  resp_cyc, 2);
    check("lbu22_data", got_rdata, 32'h000000F0);
    check("lbu22_we",   we_cnt, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h20, 32'd0);
    check("lbu20_data", got_rdata, 32'h0000008C);

    // 2. half loads
    do_req(1'b0, 2'd1, 1'b1, 32'h20, 32'd0);
    check("lh20_lat",   resp_cyc, 2);
    check("lh20_data",  got_rdata, 32'hFFFF8C0A);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'd0);
    check("lhu22_data", got_rdata, 32'h0000F0FF);
    do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'd0);
    check("lh22_data",  got_rdata, 32'hFFFFF0FF);

    // 3. byte store via read-modify-write
    do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h00000055);
    check("sb21_lat",    resp_cyc, 3);
    check("sb21_err",    {31'd0, got_err}, 32'd0);
    check("sb21_we_cnt", we_cnt, 1);
    check("sb21_we_cyc", we_cyc, 2);
    check("sb21_wdata",  we_data, 32'h8C55F0FF);
    check("sb21_waddr",  we_addr, 32'd8);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    check("lw20_data",   got_rdata, 32'h8C55F0FF);

    // 4. word store
    do_req(1'b1, 2'd2, 1'b0, 32'h24, 32'hDEADBEEF);
    check("sw24_lat",    resp_cyc, 2);
    check("sw24_we_cnt", we_cnt, 1);
    check("sw24_we_cyc", we_cyc, 1);
    check("sw24_waddr",  we_addr, 32'd9);
    check("sw24_wdata",  we_data, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h24, 32'd0);
    check("lw24_lat",    resp_cyc, 2);
    check("lw24_data",   got_rdata, 32'hDEADBEEF);

    // 5. error cases: misaligned word, misaligned half, out of range
    do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'd0);
    check("lw22_lat",   resp_cyc, 1);
    check("lw22_err",   {31'd0, got_err}, 32'd1);
    check("lw22_we",    we_cnt, 0);
    check("lw22_rdata", got_rdata, 32'hDEADBEEF);
    do_req(1'b1, 2'd1, 1'b0, 32'h21, 32'h00001234);
    check("sh21_lat",   resp_cyc, 1);
    check("sh21_err",   {31'd0, got_err}, 32'd1);
    check("sh21_we",    we_cnt, 0);
    check("sh21_rdata", got_rdata, 32'hDEADBEEF);
    do_req(1'b1, 2'd2, 1'b0, 32'h1000, 32'h11111111);
    check("sw1000_lat",   resp_cyc, 1);
    check("sw1000_err",   {31'd0, got_err}, 32'd1);
    check("sw1000_we",    we_cnt, 0);
    check("sw1000_rdata", got_rdata, 32'hDEADBEEF);
    do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'd0);
    check("size3_err",    {31'd0, got_err}, 32'd1);
    check("mem8_after_err", mem[8], 32'h8C55F0FF);

    // 6. reset during RMW_RD of a half store
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_size   = 2'd1;
    req_signed = 1'b0;
    req_addr   = 32'h20;
    req_wdata  = 32'h0000ABCD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("sh20_busy_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready",      {31'd0, req_ready},  32'd1);
    check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("midrst_mem_we",     {31'd0, mem_we},     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bad_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_we || resp_valid) bad_cnt++;
    end
    check("midrst_no_activity", bad_cnt, 0);
    check("midrst_mem8",        mem[8], 32'h8C55F0FF);
    @(posedge clk);
    #1;
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    check("post_rst_lw_lat",  resp_cyc, 2);
    check("post_rst_lw_data", got_rdata, 32'h8C55F0FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
